// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised pipelined multiplier.
// The tag side-channel is enabled by defining MULT_TAG_EN.
package mult_pkg;

  localparam int MAX_WIDTH = 32;

  // One pipeline stage; fields are sized for MAX_WIDTH and narrower builds use the low bits.
  typedef struct packed {
    logic                   valid;
    logic                   sgn;
    logic [2*MAX_WIDTH-1:0] x_ext;
    logic [MAX_WIDTH-1:0]   y_rem;
    logic [2*MAX_WIDTH-1:0] acc;
  } stage_rec_t;

  function automatic int calc_stages(input int width, input int rows_per_stage);
    return (width + rows_per_stage - 1) / rows_per_stage;
  endfunction

endpackage

// File: rtl/pp_accum_stage.sv
// Combinational adder of one group of partial-product rows into a running sum.
// In signed mode the operand MSB row carries negative weight and is subtracted.
module pp_accum_stage #(
  parameter int WIDTH         = 8,
  parameter int FIRST_ROW     = 0,
  parameter int ROW_CNT       = 2,
  parameter bit HOLDS_MSB_ROW = (FIRST_ROW + ROW_CNT == WIDTH)
) (
  input  logic                 i_sgn,
  input  logic [2*WIDTH-1:0]   i_x_ext,
  input  logic [ROW_CNT-1:0]   i_y_rows,
  input  logic [2*WIDTH-1:0]   i_acc,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [2*WIDTH-1:0] w_row;

  // NOTE: blocking assignments here on purpose: each row builds on the sum left by the previous one.
  always_comb begin
    w_row = '0;
    o_acc = i_acc;
    for (int j = 0; j < ROW_CNT; j++) begin
      w_row = i_y_rows[j] ? (i_x_ext << (FIRST_ROW + j)) : '0;
      if (HOLDS_MSB_ROW && (j == ROW_CNT - 1) && i_sgn)
        o_acc = o_acc - w_row;
      else
        o_acc = o_acc + w_row;
    end
  end

endmodule

// File: rtl/pipelined_multiplier_param.sv
// Parametrised WIDTH x WIDTH multiplier (unsigned or signed per transaction) with a
// valid/ready handshake and whole-pipeline stall. Define MULT_TAG_EN to add in_tag/out_tag.
module pipelined_multiplier_param
  import mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2
`ifdef MULT_TAG_EN
  ,
  parameter int TAG_W          = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z
`ifdef MULT_TAG_EN
  ,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [TAG_W-1:0]     out_tag
`endif
);

  localparam int STAGES = calc_stages(WIDTH, ROWS_PER_STAGE);
  localparam int PW     = 2 * WIDTH;

  logic          w_adv;
  logic [PW-1:0] w_x_ext;

  // The whole pipeline moves as one; bubbles are not compacted during a stall.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_x_ext  = in_signed ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST = k * ROWS_PER_STAGE;
    localparam int CNT   = (WIDTH - FIRST < ROWS_PER_STAGE) ? (WIDTH - FIRST) : ROWS_PER_STAGE;

    stage_rec_t    w_in;
    stage_rec_t    w_next;
    stage_rec_t    r_rec;
    logic [PW-1:0] w_acc;
`ifdef MULT_TAG_EN
    logic [TAG_W-1:0] w_tag_in;
    logic [TAG_W-1:0] r_tag;
`endif

    if (k == 0) begin : g_head
      assign w_in = '{valid: in_valid,
                      sgn:   in_signed,
                      x_ext: (2*MAX_WIDTH)'(w_x_ext),
                      y_rem: MAX_WIDTH'(y),
                      acc:   '0};
`ifdef MULT_TAG_EN
      assign w_tag_in = in_tag;
`endif
    end else begin : g_body
      assign w_in = g_stage[k-1].r_rec;
`ifdef MULT_TAG_EN
      assign w_tag_in = g_stage[k-1].r_tag;
`endif
    end

    pp_accum_stage #(
      .WIDTH         (WIDTH),
      .FIRST_ROW     (FIRST),
      .ROW_CNT       (CNT),
      .HOLDS_MSB_ROW (FIRST + CNT == WIDTH)
    ) u_accum (
      .i_sgn    (w_in.sgn),
      .i_x_ext  (w_in.x_ext[PW-1:0]),
      .i_y_rows (w_in.y_rem[CNT-1:0]),
      .i_acc    (w_in.acc[PW-1:0]),
      .o_acc    (w_acc)
    );

    assign w_next = '{valid: w_in.valid,
                      sgn:   w_in.sgn,
                      x_ext: w_in.x_ext,
                      y_rem: w_in.y_rem >> CNT,
                      acc:   (2*MAX_WIDTH)'(w_acc)};

    // NOTE: non-blocking for all clocked state; the full record is reset, not just valid, so z reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rec <= '0;
`ifdef MULT_TAG_EN
        r_tag <= '0;
`endif
      end else if (w_adv) begin
        r_rec <= w_next;
`ifdef MULT_TAG_EN
        r_tag <= w_tag_in;
`endif
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_rec.valid;
  assign z         = g_stage[STAGES-1].r_rec.acc[PW-1:0];
`ifdef MULT_TAG_EN
  assign out_tag   = g_stage[STAGES-1].r_tag;
`endif

endmodule

// File: tb/tb_pipelined_multiplier_param.sv
// Self-checking bench: directed WIDTH=8 tests plus a concurrent parameter sweep,
// each using a queue scoreboard. Tag checks are active when MULT_TAG_EN is defined.
module tb_pipelined_multiplier_param;

  int n_checks = 0;
  int n_errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product using a plain multiply of extended operands, reduced to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb, p;
    ea = $signed({32'd0, a});
    eb = $signed({32'd0, b});
    if (s && a[w-1]) ea = ea - (64'sd1 <<< w);
    if (s && b[w-1]) eb = eb - (64'sd1 <<< w);
    p = ea * eb;
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // ---------------- main DUT: WIDTH=8, ROWS_PER_STAGE=2, four stages ----------------
  logic        rst_n, in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  x, y;
  logic [15:0] z;
  logic [63:0] mq[$];
  int          m_pops = 0;
`ifdef MULT_TAG_EN
  logic [3:0]  in_tag, out_tag, tag_ctr;
  logic [3:0]  mtq[$];
`endif

  pipelined_multiplier_param #(.WIDTH(8), .ROWS_PER_STAGE(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
`ifdef MULT_TAG_EN
    ,
    .in_tag    (in_tag),
    .out_tag   (out_tag)
`endif
  );

  // One cycle: drive after the falling edge, then score what the next rising edge will transfer.
  task automatic step(input logic v, input logic s, input logic [7:0] xa, input logic [7:0] ya,
                      input logic ordy, output logic took);
    @(negedge clk);
    in_valid = v; in_signed = s; x = xa; y = ya; out_ready = ordy;
`ifdef MULT_TAG_EN
    in_tag = tag_ctr;
`endif
    #1;
    took = 1'b0;
    if (out_valid && out_ready) begin
      if (mq.size() == 0) check("m_extra_out", mq.size(), 1);
      else begin
        check("m_z", z, mq.pop_front());
`ifdef MULT_TAG_EN
        check("m_tag", out_tag, mtq.pop_front());
`endif
      end
      m_pops++;
    end
    if (in_valid && in_ready) begin
      mq.push_back(ref_mul(8, s, 32'(xa), 32'(ya)));
`ifdef MULT_TAG_EN
      mtq.push_back(tag_ctr);
      tag_ctr = tag_ctr + 4'd1;
`endif
      took = 1'b1;
    end
  endtask

  // Single isolated transaction; measures cycles from acceptance to out_valid.
  task automatic measure(input string tag, input logic s, input logic [7:0] xa,
                         input logic [7:0] ya, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_signed = s; x = xa; y = ya; out_ready = 1'b1;
`ifdef MULT_TAG_EN
    in_tag = 4'hA;
`endif
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_z"}, z, exp);
`ifdef MULT_TAG_EN
    check({tag, "_tag"}, out_tag, 4'hA);
`endif
  endtask

  // ---------------- parameter sweep DUTs ----------------
  localparam int NCFG = 8;
  localparam int CFG_W [NCFG] = '{2, 2, 5, 5, 5, 16, 16, 16};
  localparam int CFG_R [NCFG] = '{1, 2, 1, 3, 5, 1,  3,  16};

  logic sw_rst_n;
  int   sw_done_cnt = 0;

  initial begin
    sw_rst_n = 1'b0;
    #22 sw_rst_n = 1'b1;
  end

  for (genvar g = 0; g < NCFG; g++) begin : g_sw
    localparam int W = CFG_W[g];
    localparam int R = CFG_R[g];

    logic           iv, ir, sg, ov, ordy;
    logic [W-1:0]   xx, yy;
    logic [2*W-1:0] zz;
    logic [63:0]    q[$];
`ifdef MULT_TAG_EN
    logic [3:0]     itag, otag;
    logic [3:0]     tq[$];
`endif

    pipelined_multiplier_param #(.WIDTH(W), .ROWS_PER_STAGE(R)) u_sw (
      .clk       (clk),
      .rst_n     (sw_rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_signed (sg),
      .x         (xx),
      .y         (yy),
      .out_valid (ov),
      .out_ready (ordy),
      .z         (zz)
`ifdef MULT_TAG_EN
      ,
      .in_tag    (itag),
      .out_tag   (otag)
`endif
    );

    initial begin : sw_run
      int total, sent, got, cyc;
      total = (W <= 5) ? (2 << (2 * W)) : 300;
      sent = 0; got = 0; cyc = 0;
      iv = 1'b0; sg = 1'b0; xx = '0; yy = '0; ordy = 1'b0;
`ifdef MULT_TAG_EN
      itag = '0;
`endif
      wait (sw_rst_n == 1'b1);
      while ((sent < total || got < sent) && cyc < 40 * total + 100) begin
        @(negedge clk);
        if (W <= 5) begin
          sg = ((sent >> (2 * W)) & 1) != 0;
          xx = W'(sent);
          yy = W'(sent >> W);
        end else begin
          sg = 1'($urandom_range(0, 1));
          xx = W'($urandom);
          yy = W'($urandom);
        end
        iv   = (sent < total) && ($urandom_range(0, 4) != 0);
        ordy = ($urandom_range(0, 3) != 0);
`ifdef MULT_TAG_EN
        itag = 4'(sent);
`endif
        #1;
        if (ov && ordy) begin
          if (q.size() == 0) check($sformatf("sw%0d_extra_out", g), q.size(), 1);
          else begin
            check($sformatf("sw%0d_z", g), 64'(zz), q.pop_front());
`ifdef MULT_TAG_EN
            check($sformatf("sw%0d_tag", g), otag, tq.pop_front());
`endif
          end
          got++;
        end
        if (iv && ir) begin
          q.push_back(ref_mul(W, sg, 32'(xx), 32'(yy)));
`ifdef MULT_TAG_EN
          tq.push_back(itag);
`endif
          sent++;
        end
        cyc++;
      end
      check($sformatf("sw%0d_results", g), got, total);
      check($sformatf("sw%0d_leftover", g), q.size(), 0);
      sw_done_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic        took;
    int          n_acc, guard, base_pops;
    logic [15:0] z_hold;

    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; x = '0; y = '0; out_ready = 1'b0;
`ifdef MULT_TAG_EN
    in_tag = '0; tag_ctr = '0;
`endif
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    measure("u_max", 1'b0, 8'd255, 8'd255, 16'hFE01);
    measure("s_minsq", 1'b1, 8'h80, 8'h80, 16'h4000);
    measure("s_max_min", 1'b1, 8'h7F, 8'h80, 16'hC080);
    measure("s_neg1", 1'b1, 8'hFF, 8'h01, 16'hFFFF);

    // Back-to-back at full rate: results on 20 consecutive cycles.
    for (int k = 0; k < 25; k++) begin
      step(k < 20, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, took);
      if (k < 20) check("b2b_accept", took, 1);
      if (k >= 4 && k < 24) check("b2b_out_valid", out_valid, 1);
      if (k == 24) check("b2b_done", out_valid, 0);
    end
    check("b2b_drained", mq.size(), 0);

    // Backpressure: six stalled cycles mid-stream.
    n_acc = 0;
    base_pops = m_pops;
    z_hold = '0;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), c < 10, took);
      n_acc += int'(took);
      if (c == 10) begin
        check("bp_out_valid_at_stall", out_valid, 1);
        z_hold = z;
      end
      if (c >= 10) check("bp_in_ready", in_ready, 0);
      if (c > 10) begin
        check("bp_z_hold", z, z_hold);
        check("bp_out_valid_hold", out_valid, 1);
      end
    end
    guard = 0;
    while (n_acc < 25 && guard < 100) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1, took);
      n_acc += int'(took);
      guard++;
    end
    guard = 0;
    while (mq.size() > 0 && guard < 100) begin
      step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, took);
      guard++;
    end
    check("bp_drained", mq.size(), 0);
    check("bp_count", m_pops - base_pops, n_acc);

    // Reset with transactions in flight and a result waiting at the output.
    for (int k = 0; k < 5; k++)
      step(k < 4, 1'b0, 8'(k + 3), 8'd7, k < 4, took);
    check("mid_out_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_z", z, 0);
    check("mid_rst_in_ready", in_ready, 1);
    mq.delete();
`ifdef MULT_TAG_EN
    mtq.delete();
`endif
    @(negedge clk);
    rst_n = 1'b1;
    measure("after_rst", 1'b0, 8'd200, 8'd3, 16'h0258);

    guard = 0;
    while (sw_done_cnt < NCFG && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    check("sweep_done", sw_done_cnt, NCFG);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
